// File: rtl/cic_interpolator.sv
// 2nd-order CIC interpolator: two low-rate combs, zero-stuffing, two clk-rate integrators.
// Optional output clamping is enabled by defining CIC_INTERP_SAT_EN; otherwise the output wraps.
module cic_interpolator #(
  parameter int R            = 6,
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 16,
  parameter int ACC_WIDTH    = 24,
  parameter int OUT_SHIFT    = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enabled,
  input  logic signed [INPUT_WIDTH-1:0]  data_in,
  input  logic                           data_in_valid,
  output logic                           sample_req,
  output logic signed [OUTPUT_WIDTH-1:0] data_out,
  output logic                           data_out_valid,
  output logic                           underrun
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;
  localparam logic [PW-1:0] LAST_PHASE = PW'(R - 1);

  logic [PW-1:0]                  r_phase;
  logic [PW-1:0]                  w_phase_nxt;
  logic                           r_sample_req;
  logic                           r_underrun;
  logic                           r_dout_valid;
  logic signed [OUTPUT_WIDTH-1:0] r_dout;
  logic                           r_cap_d1;
  logic                           r_cap_d2;
  logic                           r_up_en;
  logic signed [ACC_WIDTH-1:0]    r_in;
  logic signed [ACC_WIDTH-1:0]    r_comb1_out;
  logic signed [ACC_WIDTH-1:0]    r_comb1_dly;
  logic signed [ACC_WIDTH-1:0]    r_comb2_out;
  logic signed [ACC_WIDTH-1:0]    r_comb2_dly;
  logic signed [ACC_WIDTH-1:0]    r_integ1;
  logic signed [ACC_WIDTH-1:0]    r_integ2;
  logic signed [ACC_WIDTH-1:0]    w_in_ext;
  logic signed [ACC_WIDTH-1:0]    w_up;
  logic signed [OUTPUT_WIDTH-1:0] w_narrow;

  assign w_phase_nxt = (r_phase == LAST_PHASE) ? '0 : r_phase + 1'b1;
  assign w_in_ext    = {{(ACC_WIDTH-INPUT_WIDTH){data_in[INPUT_WIDTH-1]}}, data_in};
  // Zero-stuffer: comb output enters the integrators for a single cycle per sample.
  assign w_up        = r_up_en ? r_comb2_out : '0;

`ifdef CIC_INTERP_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((64'sd1 <<< (OUTPUT_WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;
  logic signed [ACC_WIDTH-1:0] w_shifted;
  assign w_shifted = r_integ2 >>> OUT_SHIFT;
  always_comb begin
    w_narrow = w_shifted[OUTPUT_WIDTH-1:0];
    if (w_shifted > SAT_MAX)      w_narrow = SAT_MAX[OUTPUT_WIDTH-1:0];
    else if (w_shifted < SAT_MIN) w_narrow = SAT_MIN[OUTPUT_WIDTH-1:0];
  end
`else
  assign w_narrow = OUTPUT_WIDTH'(r_integ2 >>> OUT_SHIFT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase      <= '0;
      r_sample_req <= 1'b1;
      r_underrun   <= 1'b0;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_cap_d1     <= 1'b0;
      r_cap_d2     <= 1'b0;
      r_up_en      <= 1'b0;
      r_in         <= '0;
      r_comb1_out  <= '0;
      r_comb1_dly  <= '0;
      r_comb2_out  <= '0;
      r_comb2_dly  <= '0;
      r_integ1     <= '0;
      r_integ2     <= '0;
    end else begin
      r_dout_valid <= enabled;
      if (enabled) begin
        r_phase      <= w_phase_nxt;
        r_sample_req <= (w_phase_nxt == '0);
        r_cap_d1     <= r_sample_req;
        r_cap_d2     <= r_cap_d1;
        r_up_en      <= r_cap_d2;
        if (r_sample_req) begin
          // A missing sample is replaced by zero and remembered until reset.
          r_in <= data_in_valid ? w_in_ext : '0;
          if (!data_in_valid) r_underrun <= 1'b1;
        end
        if (r_cap_d1) begin
          r_comb1_out <= r_in - r_comb1_dly;
          r_comb1_dly <= r_in;
        end
        if (r_cap_d2) begin
          r_comb2_out <= r_comb1_out - r_comb2_dly;
          r_comb2_dly <= r_comb1_out;
        end
        r_integ1 <= r_integ1 + w_up;
        r_integ2 <= r_integ2 + r_integ1;
        r_dout   <= w_narrow;
      end
    end
  end

  assign sample_req     = r_sample_req;
  assign data_out       = r_dout;
  assign data_out_valid = r_dout_valid;
  assign underrun       = r_underrun;

endmodule

// File: tb/tb_cic_interpolator.sv
// Scoreboard bench for cic_interpolator: reference output is the zero-stuffed input
// convolved with the 2R-1 tap triangle, delayed by 5 enabled edges.
module tb_cic_interpolator;
  localparam int R  = 6;
  localparam int IW = 16;
  localparam int OW = 16;
  localparam int AW = 24;
  localparam int SH = 2;
  localparam longint S_MAX = (64'sd1 <<< (OW-1)) - 1;
  localparam longint S_MIN = -S_MAX - 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enabled = 1'b0;
  logic signed [IW-1:0] data_in = '0;
  logic                 data_in_valid = 1'b0;
  logic                 sample_req;
  logic signed [OW-1:0] data_out;
  logic                 data_out_valid;
  logic                 underrun;

  cic_interpolator #(.R(R), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .ACC_WIDTH(AW), .OUT_SHIFT(SH)) dut (
    .clk(clk), .rst_n(rst_n), .enabled(enabled), .data_in(data_in), .data_in_valid(data_in_valid),
    .sample_req(sample_req), .data_out(data_out), .data_out_valid(data_out_valid), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                 valid;
    logic                 sreq;
    logic                 unr;
    logic signed [OW-1:0] dout;
  } ctl_t;

  int n_cmp = 0;
  int n_bad = 0;
  ctl_t                 q_ctl[$];
  logic signed [OW-1:0] q_data[$];
  longint               x_hist[$];
  int                   n_edge = 0;
  logic                 m_unr = 1'b0;
  logic signed [OW-1:0] m_last = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic signed [OW-1:0] ref_out(input int n);
    longint acc;
    longint sv;
    logic signed [AW-1:0] t;
    acc = 0;
    for (int m = 0; m < x_hist.size(); m++) begin
      int j;
      j = n - 5 - m*R;
      if (j >= 0 && j <= 2*R-2) acc += x_hist[m] * longint'((j < R) ? j + 1 : 2*R - 1 - j);
    end
    t = acc[AW-1:0];
    t = t >>> SH;
    sv = longint'(t);
`ifdef CIC_INTERP_SAT_EN
    if (sv > S_MAX) return OW'(S_MAX);
    if (sv < S_MIN) return OW'(S_MIN);
`endif
    return t[OW-1:0];
  endfunction

  task automatic step(input logic en, input logic signed [IW-1:0] d, input logic v);
    ctl_t c;
    enabled = en; data_in = d; data_in_valid = v;
    @(posedge clk);
    if (en) begin
      if (n_edge % R == 0) begin
        x_hist.push_back(v ? longint'(d) : 64'sd0);
        if (!v) m_unr = 1'b1;
      end
      m_last = ref_out(n_edge);
      q_data.push_back(m_last);
      n_edge++;
    end
    c.valid = en; c.sreq = (n_edge % R == 0); c.unr = m_unr; c.dout = m_last;
    q_ctl.push_back(c);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_dout", data_out, 0);
    chk("rst_valid", data_out_valid, 0);
    chk("rst_sreq", sample_req, 1);
    chk("rst_underrun", underrun, 0);
    x_hist.delete(); n_edge = 0; m_unr = 1'b0; m_last = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    chk("rel_sreq", sample_req, 1);
  endtask

  always @(negedge clk) begin
    if (q_ctl.size() > 0) begin
      ctl_t c;
      c = q_ctl.pop_front();
      chk("valid", data_out_valid, c.valid);
      chk("sample_req", sample_req, c.sreq);
      chk("underrun", underrun, c.unr);
      if (!data_out_valid) chk("held_dout", data_out, c.dout);
    end
    if (data_out_valid) begin
      if (q_data.size() == 0) chk("unexpected_out", 1, 0);
      else chk("data_out", data_out, q_data.pop_front());
    end
  end

  initial begin
    #12;
    chk("init_dout", data_out, 0);
    chk("init_valid", data_out_valid, 0);
    chk("init_sreq", sample_req, 1);
    chk("init_underrun", underrun, 0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // impulse
    step(1'b1, 16'sd8, 1'b1);
    repeat (29) step(1'b1, 16'sd0, 1'b1);

    // DC
    repeat (60) step(1'b1, 16'sd1000, 1'b1);
    chk("dc_1000", data_out, 1500);

    // enable gap 1,0,0,1 then random enables/data
    step(1'b1, 16'sd1000, 1'b1);
    step(1'b0, 16'sd1000, 1'b1);
    step(1'b0, 16'sd1000, 1'b1);
    step(1'b1, 16'sd1000, 1'b1);
    repeat (80) step($urandom_range(0, 3) != 0, IW'($urandom), 1'b1);

    // underrun
    repeat (12) step(1'b1, IW'($urandom), 1'b1);
    repeat (6) step(1'b1, IW'($urandom), 1'b0);
    chk("underrun_set", underrun, 1);
    repeat (40) step(1'b1, IW'($urandom), $urandom_range(0, 4) != 0);

    // reset mid-triangle
    step(1'b1, 16'sd8, 1'b1);
    repeat (10) step(1'b1, 16'sd0, 1'b1);
    do_reset();
    repeat (18) step(1'b1, 16'sd0, 1'b1);
    chk("post_rst_zero", data_out, 0);

    // full-scale DC
    repeat (60) step(1'b1, 16'sd32767, 1'b1);
`ifdef CIC_INTERP_SAT_EN
    chk("fullscale", data_out, 32767);
`else
    chk("fullscale", data_out, -16386);
`endif

    enabled = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("q_data_drain", q_data.size(), 0);
    chk("q_ctl_drain", q_ctl.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cic_interpolator.md
CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 The module SHALL have parameter R, default 6: interpolation factor, legal range 2..64.
REQ-002 The module SHALL have parameter INPUT_WIDTH, default 16: signed input sample width.
REQ-003 The module SHALL have parameter OUTPUT_WIDTH, default 16: signed output sample width.
REQ-004 The module SHALL have parameter ACC_WIDTH, default 24: internal comb/integrator width, at least INPUT_WIDTH+2*clog2(R).
REQ-005 The module SHALL have parameter OUT_SHIFT, default 2: arithmetic right shift applied before output narrowing.
REQ-006 The module SHALL have input clk, 1 bit: single clock, rising edge.
REQ-007 The module SHALL have input rst_n, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have input enabled, 1 bit: clock enable for all state.
REQ-009 The module SHALL have input data_in, signed INPUT_WIDTH bits: low-rate sample.
REQ-010 The module SHALL have input data_in_valid, 1 bit: data_in holds a fresh sample.
REQ-011 The module SHALL have output sample_req, 1 bit: data_in is captured at the end of this cycle.
REQ-012 The module SHALL have output data_out, signed OUTPUT_WIDTH bits, registered: high-rate sample.
REQ-013 The module SHALL have output data_out_valid, 1 bit, registered: data_out was updated on the last edge.
REQ-014 The module SHALL have output underrun, 1 bit: sticky flag marking a missed input sample.

Function
REQ-015 The block SHALL implement a 2nd-order CIC interpolator with differential delay 1: two combs at the low rate, a zero-stuffing stage, then two integrators at the clk rate.
REQ-016 On any edge where enabled is low, all state, including the phase counter and data_out, SHALL hold, and data_out_valid SHALL go to 0.
REQ-017 On each enabled edge, the phase counter SHALL advance 0..R-1 and wrap from R-1 to 0; sample_req SHALL be registered and high exactly while phase==0.
REQ-018 On an enabled edge with sample_req=1, in_reg SHALL load sign-extended data_in if data_in_valid=1; otherwise in_reg SHALL load 0 and underrun SHALL set.
REQ-019 On the enabled edge one cycle after capture: comb1_out <= in_reg - comb1_dly and comb1_dly <= in_reg.
REQ-020 On the enabled edge two cycles after capture: comb2_out <= comb1_out - comb2_dly and comb2_dly <= comb1_out.
REQ-021 The upsampler value SHALL equal comb2_out for exactly one enabled cycle (the third after capture) and 0 in all other cycles.
REQ-022 On every enabled edge: integ1 <= integ1 + up, integ2 <= integ2 + integ1, data_out <= narrow(integ2 >>> OUT_SHIFT), and data_out_valid <= 1.
REQ-023 All ACC_WIDTH arithmetic SHALL be two's-complement and wrap modulo 2^ACC_WIDTH; wrap in the integrators is legal.
REQ-024 Latency SHALL be 5 enabled edges from the capture edge to the first data_out carrying that sample's contribution.
REQ-025 DC gain SHALL be R / 2^OUT_SHIFT, and the impulse response SHALL be the 2R-1-tap triangle 1,2,..,R,..,2,1.

Reset
REQ-026 While rst_n is low, the reset SHALL take effect asynchronously: phase=0, sample_req=1, data_out=0, data_out_valid=0, underrun=0, and all comb, delay and integrator registers = 0.
REQ-027 A reset asserted mid-operation SHALL discard all in-flight samples; the first capture after release SHALL be the first enabled edge.

Configuration
REQ-028 When macro CIC_INTERP_SAT_EN is defined, narrow() SHALL clamp to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
REQ-029 When CIC_INTERP_SAT_EN is not defined, narrow() SHALL take the low OUTPUT_WIDTH bits of the shifted value (wraps on overflow).

Verification
REQ-030 R=6, OUT_SHIFT=0, impulse data_in=8 then zeros, valid=1 -> data_out from 5th edge: 8,16,24,32,40,48,40,32,24,16,8, then 0.
REQ-031 R=6, OUT_SHIFT=2, constant data_in=1000 -> data_out settles at 1500 and stays constant; sample_req pulses every 6 enabled cycles.
REQ-032 Constant data_in=32767, OUT_SHIFT=2 -> 32767 held with CIC_INTERP_SAT_EN; wrapped value -16386 without it.
REQ-033 data_in_valid=0 at one sample_req cycle -> that sample is treated as 0 and underrun=1 until rst_n is asserted.
REQ-034 enabled toggled 1,0,0,1 mid-stream -> phase and data_out frozen, data_out_valid=0 during the gap, and the output sequence matches the enabled-only reference.
REQ-035 rst_n pulsed low mid-triangle -> all outputs reset immediately; after release, output is 0 until new input arrives and sample_req=1 on the first cycle.
